apb_regbank: RTL and testbench

- Parametrised APB slave register bank; successor to the single read-only APB register.
- Provides NUM_RW read/write control registers and NUM_RO read-only status registers behind one APB port.
- Supports programmable wait states (PREADY) and error response (PSLVERR).
- Sits between the APB interconnect and a peripheral core: drives control fields out, samples status fields in.

---
 rtl/apb_regbank.sv | 165 ++++++++++++++++
 tb/tb_apb_regbank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
// apb_regbank: parametrised APB slave register bank.
//   NUM_RW read/write control registers at word indices 0..NUM_RW-1, driven
//   out on rw_out; NUM_RO read-only status registers at indices
//   NUM_RW..NUM_RW+NUM_RO-1, shadowed every cycle from ro_in.
//   Programmable wait states (WAIT_STATES) and PSLVERR on out-of-range
//   access or write to a read-only index.
// Ports:
//   PCLK, PRESET          clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE APB control
//   PADDR [AWIDTH]        register word index
//   PWDATA/PRDATA [DWIDTH] write data in / registered read data out
//   PREADY, PSLVERR       completion / error response
//   PSTRB [DWIDTH/8]      byte strobes (only with APB_REGBANK_PSTRB_EN)
//   ro_in  [NUM_RO*DWIDTH] status inputs, slice k -> RO register k
//   rw_out [NUM_RW*DWIDTH] RW register contents, slice k = RW register k
// Optional feature macro: APB_REGBANK_PSTRB_EN (byte-strobed writes).
module apb_regbank #(
  parameter int unsigned       DWIDTH      = 8,
  parameter int unsigned       AWIDTH      = 4,
  parameter int unsigned       NUM_RW      = 2,
  parameter int unsigned       NUM_RO      = 2,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [DWIDTH-1:0] RW_RESET    = '0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [AWIDTH-1:0]        PADDR,
  input  logic [DWIDTH-1:0]        PWDATA,
`ifdef APB_REGBANK_PSTRB_EN
  input  logic [DWIDTH/8-1:0]      PSTRB,
`endif
  output logic [DWIDTH-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [NUM_RO*DWIDTH-1:0] ro_in,
  output logic [NUM_RW*DWIDTH-1:0] rw_out
);

  localparam int unsigned NBYTES = DWIDTH / 8;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                         state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic [AWIDTH-1:0]              addr_q;
  logic                           write_q;
  logic [DWIDTH-1:0]              wdata_q;
  logic [NBYTES-1:0]              strb_q;
  logic                           err_q;
  logic [NUM_RW-1:0][DWIDTH-1:0]  rw_q;
  logic [NUM_RO-1:0][DWIDTH-1:0]  ro_q;

  logic [NBYTES-1:0]              strb_in;
  logic                           setup;
  logic                           commit;
  logic                           addr_valid;
  logic                           addr_ro;
  logic                           err_in;
  logic [DWIDTH-1:0]              rd_sel;

`ifdef APB_REGBANK_PSTRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = '1;
`endif

  assign setup   = (state_q == IDLE) & PSEL & ~PENABLE;
  assign PREADY  = (state_q == ACCESS) & PSEL & PENABLE & (cnt_q == WS);
  assign PSLVERR = PREADY & err_q;
  assign rw_out  = rw_q;

  // Address decode and read mux, evaluated on the live SETUP-phase address.
  always_comb begin
    addr_valid = 1'b0;
    addr_ro    = 1'b0;
    rd_sel     = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (PADDR == AWIDTH'(i)) begin
        addr_valid = 1'b1;
        rd_sel     = rw_q[i];
      end
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (PADDR == AWIDTH'(NUM_RW + j)) begin
        addr_valid = 1'b1;
        addr_ro    = 1'b1;
        rd_sel     = ro_q[j];
      end
    end
    err_in = ~addr_valid | (PWRITE & addr_ro);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Protocol violation: abandon the transfer without committing.
          state_d = IDLE;
        end else if (PREADY) begin
          state_d = IDLE;
          commit  = write_q & ~err_q;
        end else if (cnt_q != WS) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA  <= '0;
      rw_q    <= {NUM_RW{RW_RESET}};
      ro_q    <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ro_q <= ro_in;
      if (setup) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= strb_in;
        err_q   <= err_in;
        PRDATA  <= (PWRITE | err_in) ? '0 : rd_sel;
      end
      if (commit) begin
        for (int unsigned i = 0; i < NUM_RW; i++) begin
          if (addr_q == AWIDTH'(i)) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
              if (strb_q[b]) rw_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regbank.sv
module tb_apb_regbank;

`ifdef APB_REGBANK_PSTRB_EN
  localparam int unsigned DW = 16;
`else
  localparam int unsigned DW = 8;
`endif
  localparam int unsigned NB   = DW / 8;
  localparam logic [DW-1:0] RST0 = DW'(8'hA5);

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
  } exp_t;

  exp_t sb[$];

  logic            pclk;
  logic            preset;
  logic            psel    [2];
  logic            penable [2];
  logic            pwrite  [2];
  logic [3:0]      paddr   [2];
  logic [DW-1:0]   pwdata  [2];
  logic [NB-1:0]   strb    [2];
  logic [DW-1:0]   prdata  [2];
  logic            pready  [2];
  logic            pslverr [2];
  logic [2*DW-1:0] ro_in   [2];
  logic [2*DW-1:0] rw_out  [2];

  int errors = 0;
  int checks = 0;

  apb_regbank #(.DWIDTH(DW), .AWIDTH(4), .NUM_RW(2), .NUM_RO(2),
                .WAIT_STATES(0), .RW_RESET(RST0)) u0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_REGBANK_PSTRB_EN
    .PSTRB(strb[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .ro_in(ro_in[0]), .rw_out(rw_out[0]));

  apb_regbank #(.DWIDTH(DW), .AWIDTH(4), .NUM_RW(2), .NUM_RO(2),
                .WAIT_STATES(3), .RW_RESET('0)) u1 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_REGBANK_PSTRB_EN
    .PSTRB(strb[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .ro_in(ro_in[1]), .rw_out(rw_out[1]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the completion edge.
  task automatic xfer(input int d, input logic wr, input logic [3:0] addr,
                      input logic [DW-1:0] wdata, input logic [NB-1:0] st,
                      input logic [DW-1:0] erd, input logic eerr, input string tag);
    exp_t e;
    int   waits;
    bit   done;
    sb.push_back('{rdata: erd, err: eerr, waits: (d == 0) ? 0 : 3});
    pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata; strb[d] = st;
    psel[d] = 1'b1; penable[d] = 1'b0;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    waits = 0;
    done  = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk);
      if (pready[d]) done = 1;
      else begin
        waits++;
        @(posedge pclk); #1;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: got PREADY=0 expected PREADY=1 within 40 cycles", tag);
    end else begin
      chk({tag, "_prdata"}, 64'(prdata[d]), 64'(e.rdata));
      chk({tag, "_pslverr"}, 64'(pslverr[d]), 64'(e.err));
      chk({tag, "_waits"}, 64'(waits), 64'(e.waits));
    end
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0;
      pwdata[d] = '0; strb[d] = '1;
    end
    ro_in[0] = {DW'(8'h11), DW'(8'h22)};
    ro_in[1] = {DW'(8'hC3), DW'(8'h5A)};

    // Reset held for two edges.
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_rw_out0", 64'(rw_out[0]), 64'({RST0, RST0}));
    chk("rst_prdata0", 64'(prdata[0]), 64'(0));
    chk("rst_pready0", 64'(pready[0]), 64'(0));
    chk("rst_pslverr0", 64'(pslverr[0]), 64'(0));
    chk("rst_rw_out1", 64'(rw_out[1]), 64'(0));
    chk("rst_prdata1", 64'(prdata[1]), 64'(0));
    preset = 1'b0;
    idle(1);

    // Zero-wait write then back-to-back read of RW1.
    xfer(0, 1, 4'd1, DW'(8'h3C), '1, '0, 0, "wr_rw1");
    chk("wr_rw1_rw_out", 64'(rw_out[0]), 64'({DW'(8'h3C), RST0}));
    xfer(0, 0, 4'd1, '0, '1, DW'(8'h3C), 0, "rd_rw1");
    xfer(0, 0, 4'd0, '0, '1, RST0, 0, "rd_rw0");

    // RO reads with three wait states.
    idle(2);
    xfer(1, 0, 4'd2, '0, '1, DW'(8'h5A), 0, "rd_ro0_ws3");
    xfer(1, 0, 4'd3, '0, '1, DW'(8'hC3), 0, "rd_ro1_ws3");

    // Error responses.
    xfer(0, 1, 4'd3, DW'(8'hFF), '1, '0, 1, "wr_ro_err");
    chk("wr_ro_err_rw_out", 64'(rw_out[0]), 64'({DW'(8'h3C), RST0}));
    xfer(0, 0, 4'd3, '0, '1, DW'(8'h11), 0, "rd_ro1_after_err");
    xfer(0, 0, 4'd4, '0, '1, '0, 1, "rd_oor4");
    xfer(0, 0, 4'd15, '0, '1, '0, 1, "rd_oor15");
    xfer(0, 1, 4'd5, DW'(8'h66), '1, '0, 1, "wr_oor5");
    chk("wr_oor5_rw_out", 64'(rw_out[0]), 64'({DW'(8'h3C), RST0}));

    // Waited write, then an abort by dropping PSEL mid-ACCESS.
    xfer(1, 1, 4'd0, DW'(8'h99), '1, '0, 0, "wr_ws3");
    chk("wr_ws3_rw_out", 64'(rw_out[1]), 64'({DW'(0), DW'(8'h99)}));
    pwrite[1] = 1; paddr[1] = 4'd0; pwdata[1] = DW'(8'h77);
    psel[1] = 1; penable[1] = 0;
    @(posedge pclk); #1;
    penable[1] = 1;
    @(negedge pclk);
    chk("abort_pready_a", 64'(pready[1]), 64'(0));
    @(posedge pclk); #1;
    psel[1] = 0; penable[1] = 0;
    @(negedge pclk);
    chk("abort_pready_b", 64'(pready[1]), 64'(0));
    @(posedge pclk); #1;
    chk("abort_rw_out", 64'(rw_out[1]), 64'({DW'(0), DW'(8'h99)}));
    xfer(1, 0, 4'd0, '0, '1, DW'(8'h99), 0, "rd_after_abort");

`ifdef APB_REGBANK_PSTRB_EN
    xfer(0, 1, 4'd0, 16'h1234, 2'b11, '0, 0, "strb_full");
    xfer(0, 1, 4'd0, 16'hABCD, 2'b10, '0, 0, "strb_hi");
    chk("strb_hi_rw_out", 64'(rw_out[0][DW-1:0]), 64'(16'hAB34));
    xfer(0, 0, 4'd0, '0, 2'b00, 16'hAB34, 0, "strb_hi_rd");
    xfer(0, 1, 4'd0, 16'h5555, 2'b00, '0, 0, "strb_none");
    xfer(0, 0, 4'd0, '0, 2'b01, 16'hAB34, 0, "strb_none_rd");
`endif

    // Reset pulse during a waited write aborts it.
    pwrite[1] = 1; paddr[1] = 4'd1; pwdata[1] = DW'(8'h42);
    psel[1] = 1; penable[1] = 0;
    @(posedge pclk); #1;
    penable[1] = 1;
    preset = 1;
    @(posedge pclk); #1;
    preset = 0; psel[1] = 0; penable[1] = 0;
    @(negedge pclk);
    chk("rstpulse_pready", 64'(pready[1]), 64'(0));
    chk("rstpulse_rw_out1", 64'(rw_out[1]), 64'(0));
    chk("rstpulse_rw_out0", 64'(rw_out[0]), 64'({RST0, RST0}));
    @(posedge pclk); #1;
    xfer(1, 0, 4'd1, '0, '1, '0, 0, "rd_after_rstpulse");
    xfer(1, 1, 4'd1, DW'(8'h42), '1, '0, 0, "wr_after_rstpulse");
    xfer(1, 0, 4'd1, '0, '1, DW'(8'h42), 0, "rd_back_42");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
